// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: parallel operands fed LSB-first through a 1-bit slice, result reassembled.
// Optional SUB operation (op=100) enabled by defining ALU_SERIAL_SUB_EN.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // One-bit ALU slice: returns {carry_out, sum_bit}; unsupported ops yield zero and no carry.
  function automatic logic [1:0] slice_f(input logic [2:0] op_i, input logic a_i,
                                         input logic b_i, input logic c_i);
    logic [1:0] r;
    logic       bx;
    r  = 2'b00;
    bx = b_i;
    case (op_i)
      3'b000:  r = {1'b0, a_i & b_i};
      3'b001:  r = {1'b0, a_i | b_i};
      3'b010:  r = {1'b0, a_i ^ b_i};
      3'b011:  r = {(a_i & b_i) | (a_i & c_i) | (b_i & c_i), a_i ^ b_i ^ c_i};
`ifdef ALU_SERIAL_SUB_EN
      3'b100: begin
        bx = ~b_i;
        r  = {(a_i & bx) | (a_i & c_i) | (bx & c_i), a_i ^ bx ^ c_i};
      end
`endif
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [2:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       slice_s;
  logic [WIDTH-1:0] result_shift_s;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d        = state_q;
    a_sr_d         = a_sr_q;
    b_sr_d         = b_sr_q;
    op_d           = op_q;
    cnt_d          = cnt_q;
    carry_d        = carry_q;
    result_d       = result_q;
    cout_d         = cout_q;
    zero_d         = zero_q;
    slice_s        = slice_f(op_q, a_sr_q[0], b_sr_q[0], carry_q);
    result_shift_s = {slice_s[0], result_q[WIDTH-1:1]};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_SHIFT;
          a_sr_d   = a;
          b_sr_d   = b;
          op_d     = op;
          cnt_d    = '0;
`ifdef ALU_SERIAL_SUB_EN
          carry_d  = (op == 3'b100);
`else
          carry_d  = 1'b0;
`endif
          result_d = '0;
          cout_d   = 1'b0;
          zero_d   = 1'b0;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_SHIFT: begin
        result_d = result_shift_s;
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        carry_d  = slice_s[1];
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
          cout_d  = slice_s[1];
          zero_d  = (result_shift_s == '0);
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      op_q     <= 3'b000;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH=8); cycle cN is N clocks after start was driven.
module tb_alu_serial_seq;

  logic       clk;
  logic       rst;
  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       cout;
  logic       zero;

  int checks = 0;
  int errors = 0;

  alu_serial_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .cout  (cout),
    .zero  (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full operation from c0; checks busy window c1..c8, done in c9 and hold in c10.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [7:0] av,
                        input logic [7:0] bv, input logic [7:0] er, input logic ec,
                        input logic ez);
    op = o; a = av; b = bv; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      step();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, {24'd0, result}, {24'd0, er});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    step();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {24'd0, result}, {24'd0, er});
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'b000; a = 8'h00; b = 8'h00;
    step();
    step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {24'd0, result}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    rst = 1'b0;
    step();

    run_op("and", 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    run_op("add_wrap", 3'b011, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1);
    run_op("or", 3'b001, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0);

    // start re-pulsed at c4 with new operand must be ignored
    op = 3'b011; a = 8'h12; b = 8'h34; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step();
    start = 1'b1; a = 8'h00; op = 3'b000;
    step();
    start = 1'b0;
    for (int i = 5; i <= 8; i++) begin
      check("ign_busy", {31'd0, busy}, 32'd1);
      check("ign_nodone", {31'd0, done}, 32'd0);
      step();
    end
    check("ign_done", {31'd0, done}, 32'd1);
    check("ign_result", {24'd0, result}, 32'h46);
    check("ign_cout", {31'd0, cout}, 32'd0);
    step();
    check("ign_idle_busy", {31'd0, busy}, 32'd0);
    check("ign_idle_done", {31'd0, done}, 32'd0);

    // reset asserted in c5 of XOR aborts the operation
    op = 3'b010; a = 8'h0F; b = 8'hFF; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {24'd0, result}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("abort_nopulse", {31'd0, done}, 32'd0);
      step();
    end
    run_op("post_abort_or", 3'b001, 8'hA0, 8'h05, 8'hA5, 1'b0, 1'b0);

    // start held high: XOR 55^FF then back-to-back ADD 01+01 accepted in the done cycle
    op = 3'b010; a = 8'h55; b = 8'hFF; start = 1'b1;
    step();
    op = 3'b011; a = 8'h01; b = 8'h01;
    for (int i = 1; i <= 8; i++) begin
      check("b2b_busy1", {31'd0, busy}, 32'd1);
      step();
    end
    check("b2b_done1", {31'd0, done}, 32'd1);
    check("b2b_result1", {24'd0, result}, 32'hAA);
    check("b2b_cout1", {31'd0, cout}, 32'd0);
    step();
    start = 1'b0;
    check("b2b_rebusy", {31'd0, busy}, 32'd1);
    check("b2b_nodone", {31'd0, done}, 32'd0);
    check("b2b_cleared", {24'd0, result}, 32'd0);
    step();
    for (int i = 11; i <= 17; i++) begin
      check("b2b_busy2", {31'd0, busy}, 32'd1);
      check("b2b_nodone2", {31'd0, done}, 32'd0);
      step();
    end
    check("b2b_done2", {31'd0, done}, 32'd1);
    check("b2b_result2", {24'd0, result}, 32'h02);
    check("b2b_zero2", {31'd0, zero}, 32'd0);
    step();

`ifdef ALU_SERIAL_SUB_EN
    run_op("sub_pos", 3'b100, 8'h05, 8'h03, 8'h02, 1'b1, 1'b0);
    run_op("sub_neg", 3'b100, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
`else
    run_op("op100", 3'b100, 8'h05, 8'h03, 8'h00, 1'b0, 1'b1);
`endif
    run_op("op111", 3'b111, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1);
    run_op("xor", 3'b010, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
